// File: rtl/operand_sequencer_pkg.sv
// Shared types and sizing for the operand staging stage.
package operand_sequencer_pkg;

  localparam int OPERAND_COUNT = 4;
  localparam int SEL_W         = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FULL  = 2'd2,
    ST_ISSUE = 2'd3
  } state_e;

endpackage

// File: rtl/operand_sequencer_bank.sv
// Four-word operand register bank; outputs feed the 4:1 word mux directly.
module operand_bank
  import operand_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_en_i,
  input  logic [SEL_W-1:0] wr_idx_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] in0_o,
  output logic [WIDTH-1:0] in1_o,
  output logic [WIDTH-1:0] in2_o,
  output logic [WIDTH-1:0] in3_o
);

  logic [WIDTH-1:0] bank_q [OPERAND_COUNT];

  // Clear on reset; otherwise only the addressed slot changes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < OPERAND_COUNT; i++) bank_q[i] <= '0;
    end else if (wr_en_i) begin
      bank_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign in0_o = bank_q[0];
  assign in1_o = bank_q[1];
  assign in2_o = bank_q[2];
  assign in3_o = bank_q[3];

endmodule

// File: rtl/operand_sequencer.sv
// Operand staging stage: loads four words, then steps the mux select 0..3.
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | bank empty of pending work, waiting for the first word
// ST_LOAD  | words 1..3 being collected, wr_ptr names the next slot
// ST_FULL  | all four words held, waiting for start
// ST_ISSUE | select walks 0..3 under the sel_valid/sel_ready handshake
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             start,
  input  logic             flush,
  output logic [WIDTH-1:0] in0,
  output logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] in3,
  output logic [SEL_W-1:0] select,
  output logic             sel_valid,
  input  logic             sel_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(OPERAND_COUNT - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             done_q, done_d;
  // Registered copy of reset so load_ready stays low through the reset
  // cycle without a combinational path from any input.
  logic             rst_seen_q;
  logic             load_acc, sel_acc, bank_we;

  assign load_ready = !rst_seen_q && (state_q == ST_IDLE || state_q == ST_LOAD);
  assign sel_valid  = (state_q == ST_ISSUE);
  assign busy       = (state_q != ST_IDLE);
  assign select     = sel_q;
  assign done       = done_q;

  assign load_acc = load_valid && load_ready;
  assign sel_acc  = sel_valid && sel_ready;
  // A flushed load beat is dropped rather than written.
  assign bank_we  = load_acc && !flush;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      sel_q      <= '0;
      done_q     <= 1'b0;
      rst_seen_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      sel_q      <= sel_d;
      done_q     <= done_d;
      rst_seen_q <= 1'b0;
    end
  end

  // Next-state and counter update; flush overrides every other event.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    sel_d    = sel_q;
    done_d   = 1'b0;
    if (flush) begin
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
      sel_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (load_acc) begin
            wr_ptr_d = SEL_W'(1);
            state_d  = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (load_acc) begin
            wr_ptr_d = wr_ptr_q + SEL_W'(1);
            if (wr_ptr_q == LAST) state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (start) begin
            state_d = ST_ISSUE;
            sel_d   = '0;
          end
        end
        ST_ISSUE: begin
          if (sel_acc) begin
            sel_d = sel_q + SEL_W'(1);
            if (sel_q == LAST) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  operand_bank #(.WIDTH(WIDTH)) u_bank (
    .clk_i     (clk),
    .reset_i   (reset),
    .wr_en_i   (bank_we),
    .wr_idx_i  (wr_ptr_q),
    .wr_data_i (load_data),
    .in0_o     (in0),
    .in1_o     (in1),
    .in2_o     (in2),
    .in3_o     (in3)
  );

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: vector table, directed corner cases, random run.
module tb_operand_sequencer;

  logic        clk = 1'b0;
  logic        reset, load_valid, start, flush, sel_ready;
  logic [31:0] load_data;
  logic        load_ready, sel_valid, busy, done;
  logic [31:0] in0, in1, in2, in3;
  logic [1:0]  select;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  operand_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .start(start), .flush(flush),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .select(select), .sel_valid(sel_valid), .sel_ready(sel_ready),
    .busy(busy), .done(done)
  );

  // Reference model: counts of words held / issued rather than FSM states.
  logic [31:0] m_bank [4];
  int          m_loaded;
  bit          m_issuing;
  int          m_idx;
  bit          m_done;
  bit          m_rst;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit m_lr();
    return !m_rst && !m_issuing && (m_loaded < 4);
  endfunction

  function automatic void model_step();
    bit lr;
    if (reset) begin
      foreach (m_bank[i]) m_bank[i] = '0;
      m_loaded = 0; m_issuing = 0; m_idx = 0; m_done = 0; m_rst = 1;
      return;
    end
    lr     = m_lr();
    m_done = 0;
    if (flush) begin
      m_loaded = 0; m_issuing = 0; m_idx = 0;
    end else if (m_issuing) begin
      if (sel_ready) begin
        if (m_idx == 3) begin
          m_issuing = 0; m_idx = 0; m_loaded = 0; m_done = 1;
        end else m_idx++;
      end
    end else if (m_loaded == 4) begin
      if (start) begin m_issuing = 1; m_idx = 0; end
    end else if (load_valid && lr) begin
      m_bank[m_loaded] = load_data;
      m_loaded++;
    end
    m_rst = 0;
  endfunction

  function automatic void model_check();
    chk("m_in0", in0, m_bank[0]);
    chk("m_in1", in1, m_bank[1]);
    chk("m_in2", in2, m_bank[2]);
    chk("m_in3", in3, m_bank[3]);
    chk("m_select", 32'(select), 32'(m_idx));
    chk("m_sel_valid", 32'(sel_valid), 32'(m_issuing));
    chk("m_busy", 32'(busy), 32'(m_issuing || m_loaded > 0));
    chk("m_done", 32'(done), 32'(m_done));
    chk("m_load_ready", 32'(load_ready), 32'(m_lr()));
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  task automatic drive(input logic r, input logic lv, input logic [31:0] d,
                       input logic s, input logic sr, input logic f);
    reset = r; load_valid = lv; load_data = d; start = s; sel_ready = sr; flush = f;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic load4(input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, base + 32'(i), 0, 0, 0);
      tick();
    end
    idle();
  endtask

  task automatic go_issue();
    drive(0, 0, 32'h0, 1, 0, 0);
    tick();
    idle();
  endtask

  task automatic accept_n(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 32'h0, 0, 1, 0);
      tick();
    end
    idle();
  endtask

  typedef struct {
    logic        rst, lv;
    logic [31:0] ld;
    logic        st, sr, fl;
    logic        lr, sv;
    logic [1:0]  sel;
    logic        bsy, dn;
  } vec_t;

  function automatic vec_t mk(logic rst, logic lv, logic [31:0] ld, logic st, logic sr,
                              logic fl, logic lr, logic sv, logic [1:0] sel,
                              logic bsy, logic dn);
    vec_t v;
    v.rst = rst; v.lv = lv; v.ld = ld; v.st = st; v.sr = sr; v.fl = fl;
    v.lr = lr; v.sv = sv; v.sel = sel; v.bsy = bsy; v.dn = dn;
    return v;
  endfunction

  vec_t vt [12];

  initial begin
    // Basic load and issue; expectations are the outputs after each edge.
    //          rst lv data          st sr fl   lr sv sel bsy dn
    vt[0]  = mk(1, 0, 32'h0,        0, 0, 0,   0, 0, 0, 0, 0);
    vt[1]  = mk(0, 0, 32'h0,        0, 0, 0,   1, 0, 0, 0, 0);
    vt[2]  = mk(0, 1, 32'h11111111, 0, 0, 0,   1, 0, 0, 1, 0);
    vt[3]  = mk(0, 1, 32'h22222222, 0, 0, 0,   1, 0, 0, 1, 0);
    vt[4]  = mk(0, 1, 32'h33333333, 0, 0, 0,   1, 0, 0, 1, 0);
    vt[5]  = mk(0, 1, 32'h44444444, 0, 0, 0,   0, 0, 0, 1, 0);
    vt[6]  = mk(0, 0, 32'h0,        1, 1, 0,   0, 1, 0, 1, 0);
    vt[7]  = mk(0, 0, 32'h0,        0, 1, 0,   0, 1, 1, 1, 0);
    vt[8]  = mk(0, 0, 32'h0,        0, 1, 0,   0, 1, 2, 1, 0);
    vt[9]  = mk(0, 0, 32'h0,        0, 1, 0,   0, 1, 3, 1, 0);
    vt[10] = mk(0, 0, 32'h0,        0, 1, 0,   1, 0, 0, 0, 1);
    vt[11] = mk(0, 0, 32'h0,        0, 0, 0,   1, 0, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].rst, vt[i].lv, vt[i].ld, vt[i].st, vt[i].sr, vt[i].fl);
      tick();
      chk($sformatf("vec%0d_load_ready", i), 32'(load_ready), 32'(vt[i].lr));
      chk($sformatf("vec%0d_sel_valid", i), 32'(sel_valid), 32'(vt[i].sv));
      chk($sformatf("vec%0d_select", i), 32'(select), 32'(vt[i].sel));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].bsy));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].dn));
    end
    chk("basic_in0", in0, 32'h11111111);
    chk("basic_in1", in1, 32'h22222222);
    chk("basic_in2", in2, 32'h33333333);
    chk("basic_in3", in3, 32'h44444444);

    // Backpressure at select 1.
    load4(32'hA0000000);
    go_issue();
    accept_n(1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'h0, 0, 0, 0);
      tick();
      chk("bp_hold_select", 32'(select), 32'd1);
      chk("bp_hold_valid", 32'(sel_valid), 32'd1);
    end
    accept_n(1);
    chk("bp_resume_select", 32'(select), 32'd2);
    accept_n(2);
    chk("bp_done", 32'(done), 32'd1);
    idle(); tick();

    // Gapped load with an early start.
    drive(0, 1, 32'hB0000000, 0, 0, 0); tick();
    idle(); tick();
    drive(0, 1, 32'hB0000001, 0, 0, 0); tick();
    drive(0, 0, 32'h0, 1, 0, 0); tick();
    chk("early_start_sel_valid", 32'(sel_valid), 32'd0);
    chk("early_start_load_ready", 32'(load_ready), 32'd1);
    drive(0, 1, 32'hB0000002, 0, 0, 0); tick();
    idle(); tick();
    chk("lr_before_4th", 32'(load_ready), 32'd1);
    drive(0, 1, 32'hB0000003, 0, 0, 0); tick();
    chk("lr_after_4th", 32'(load_ready), 32'd0);
    drive(0, 1, 32'hDEADBEEF, 0, 0, 0); tick();
    chk("fifth_in0", in0, 32'hB0000000);
    chk("fifth_in3", in3, 32'hB0000003);
    chk("fifth_busy", 32'(busy), 32'd1);
    idle();
    go_issue();
    chk("gapped_issue_valid", 32'(sel_valid), 32'd1);
    accept_n(4);

    // Flush at select 2.
    load4(32'hC0000000);
    go_issue();
    accept_n(2);
    drive(0, 0, 32'h0, 0, 1, 1); tick();
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_sel_valid", 32'(sel_valid), 32'd0);
    chk("flush_select", 32'(select), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    chk("flush_in2", in2, 32'hC0000002);
    idle(); tick();
    chk("flush_no_done", 32'(done), 32'd0);

    // Flush coincident with the 4th load accept.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'hD0000000 + 32'(i), 0, 0, 0); tick();
    end
    drive(0, 1, 32'hDEADBEEF, 0, 0, 1); tick();
    chk("flush4_busy", 32'(busy), 32'd0);
    chk("flush4_in3", in3, 32'hC0000003);
    drive(0, 1, 32'hD0000009, 0, 0, 0); tick();
    chk("flush4_restart_in0", in0, 32'hD0000009);
    chk("flush4_in1_kept", in1, 32'hD0000001);
    drive(0, 0, 32'h0, 0, 0, 1); tick();
    idle();

    // Synchronous reset mid-issue, then a clean full sequence.
    load4(32'hE0000000);
    go_issue();
    accept_n(1);
    drive(1, 0, 32'h0, 0, 1, 0); tick();
    chk("rst_in0", in0, 32'h0);
    chk("rst_in3", in3, 32'h0);
    chk("rst_sel_valid", 32'(sel_valid), 32'd0);
    chk("rst_select", 32'(select), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    idle(); tick();
    load4(32'hF0000000);
    go_issue();
    accept_n(4);
    chk("post_rst_done", 32'(done), 32'd1);
    chk("post_rst_in2", in2, 32'hF0000002);

    // Randomised run against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(63) == 0, $urandom_range(1) == 1, $urandom,
            $urandom_range(2) == 0, $urandom_range(3) != 0, $urandom_range(15) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
# operand_sequencer

Four-word operand staging stage that sits directly upstream of the team's 32-bit 4:1 word multiplexer. It accepts four words over a valid/ready load port, holds them in a register bank driving the multiplexer's four data inputs, then steps the 2-bit select 0→1→2→3 under a downstream valid/ready handshake. It pulses `done` after the last word is consumed. The stage is used to serialise neuron operand groups (weights or activations) into the single-word datapath.

## Interface
- `WIDTH`, 32, data word width; applies to load data and all four bank outputs.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `load_valid` input 1: upstream word is present on `load_data`.
- `load_data` input WIDTH: word to store.
- `load_ready` output 1: stage can accept a word.
- `start` input 1: begin issue; honoured only in FULL.
- `flush` input 1: abort the current load or issue and return to IDLE.
- `in0`, `in1`, `in2`, `in3` output WIDTH each: bank words 0–3, wired to the multiplexer data inputs.
- `select` output 2: multiplexer select.
- `sel_valid` output 1: `select` addresses a live operand.
- `sel_ready` input 1: consumer accepts the current operand.
- `busy` output 1: state is not IDLE.
- `done` output 1: one-cycle pulse after the operand at select 3 is accepted.

## Operation
- FSM states: IDLE, LOAD, FULL, ISSUE.
- **IDLE**: `load_ready`=1. An accept (`load_valid`&&`load_ready`) writes bank[0], sets `wr_ptr`=1 and moves to LOAD.
- **LOAD**:
  - `load_ready`=1. Each accept writes bank[`wr_ptr`] and increments `wr_ptr`.
  - The accept at `wr_ptr`=3 moves to FULL and wraps `wr_ptr` to 0.
- **FULL**: `load_ready`=0. `start`=1 moves to ISSUE with `select`=0.
- **ISSUE**:
  - `sel_valid`=1. Each accept (`sel_valid`&&`sel_ready`) increments `select`.
  - The accept at `select`=3 moves to IDLE, resets `select` to 0 and sets `done`=1 for the next cycle.
- `start` outside FULL is ignored and not remembered.
- `flush` is evaluated in every state:
  - next state is IDLE, `wr_ptr`=0, `select`=0, `sel_valid`=0;
  - no `done` pulse;
  - bank contents are retained.
- `flush` has priority over any simultaneous load accept, `start`, or select accept.
- Bank words are retained across the whole issue phase and into the next IDLE. A word changes only when its slot is written.
- `load_valid` with `load_ready`=0 has no effect.
- Width rules:
  - `wr_ptr` and `select` are 2-bit counters; wrap 3→0 happens only on the transitions listed above.
  - Data is stored unmodified; no arithmetic is performed on it.

## Timing
- Reset values, visible the cycle after `reset` is sampled high:
  - state IDLE, bank all zero (`in0`–`in3`=0);
  - `select`=0, `wr_ptr`=0;
  - `sel_valid`=0, `busy`=0, `done`=0;
  - `load_ready`=0 while `reset` is high, then 1 once reset is released.
- Reset mid-load or mid-issue discards all progress and zeroes the bank.
- Load latency: a word accepted at edge N appears on its `inK` output after edge N.
- FULL: `load_ready` drops in the cycle after the fourth accept. There is no combinational path from `load_valid` to `load_ready`.
- Issue start: `start` sampled at edge N gives `sel_valid`=1 and `select`=0 after edge N.
- Hold rule: `select` and `sel_valid` stay stable while `sel_valid`&&!`sel_ready`.
- Throughput: one operand per cycle with `sel_ready` tied high, so four cycles in ISSUE.
- Issue end: final accept at edge M gives `done`=1, `sel_valid`=0, `busy`=0 and `load_ready`=1 after edge M. `done` returns to 0 one cycle later.
- A load accept is possible in the same cycle `done` is high.
- All outputs are registered or decoded only from registered state; none depend combinationally on inputs.

## Structure
- Shared package holds:
  - state encoding (IDLE=0, LOAD=1, FULL=2, ISSUE=3);
  - `OPERAND_COUNT`=4;
  - `SEL_W`=2.
- One sub-module, `operand_bank`: 4×WIDTH register array with write enable, 2-bit write index, synchronous clear on `reset`, and four parallel outputs.
- The FSM, `wr_ptr` and `select` counters, and handshake logic live in `operand_sequencer`.

## Test plan
- **Basic load and issue**: reset, then load 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back, pulse `start`, hold `sel_ready`=1.
  - `in0`–`in3` hold these values.
  - `select` reads 0,1,2,3 over 4 cycles with `sel_valid`=1.
  - `done`=1 for exactly one cycle, then `busy`=0.
- **Backpressure**: during ISSUE, drive `sel_ready`=0 for 3 cycles at `select`=1.
  - `select` stays 1 and `sel_valid` stays 1 throughout.
  - Issue resumes to 2 when `sel_ready` returns to 1.
- **Gapped load with early start**: insert `load_valid`=0 gaps and assert `start` after 2 words.
  - `start` is ignored; state stays LOAD.
  - `load_ready` drops only after the 4th word.
  - A 5th `load_valid` is not accepted.
- **Flush**:
  - Flush at `select`=2 → IDLE next cycle, no `done`, bank unchanged.
  - Flush coincident with the 4th load accept → state IDLE and `wr_ptr`=0; that word is not written.
- **Synchronous reset mid-issue**: assert `reset` at `select`=1.
  - Next cycle `in0`–`in3`=0, `sel_valid`=0, `select`=0, `done`=0.
  - After release, a full load/issue sequence completes normally.
